// File: rtl/sa_input_skewer.sv
// Row collector and diagonal skewer feeding the FP32-activation systolic array.
// Optional feature macro: SA_SKEW_ROWCNT_EN adds the 16-bit rows_streamed_o counter.
module sa_input_skewer #(
   parameter int SA_SIZE         = 8,
   parameter int ACTIVATION_SIZE = 32,
   parameter int DRAIN_STEPS     = 2*SA_SIZE-2
) (
   input  logic                                    clk,
   input  logic                                    resetn,
   input  logic                                    in_valid_i,
   output logic                                    in_ready_o,
   input  logic [ACTIVATION_SIZE-1:0]              in_data_i,
   input  logic                                    drain_i,
   output logic                                    stream_o,
   output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] sa_inputs_o,
   output logic                                    busy_o,
   output logic                                    done_o
`ifdef SA_SKEW_ROWCNT_EN
   ,
   output logic [15:0]                             rows_streamed_o
`endif
);

   localparam int CW    = $clog2(SA_SIZE);
   localparam int DCW   = $clog2(DRAIN_STEPS + 1);
   localparam int N_DLY = SA_SIZE * (SA_SIZE - 1) / 2;
   localparam logic [CW-1:0]  LAST_WORD  = CW'(SA_SIZE - 1);
   localparam logic [DCW-1:0] DRAIN_INIT = DCW'(DRAIN_STEPS);

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_STEP  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e                                  state_q, state_d;
   logic [CW-1:0]                           word_cnt_q, word_cnt_d;
   logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] staging_q, staging_d;
   logic [N_DLY-1:0][ACTIVATION_SIZE-1:0]   dly_q, dly_d;
   logic                                    drain_pending_q, drain_pending_d;
   logic [DCW-1:0]                          drain_cnt_q, drain_cnt_d;
   logic                                    stream_q, stream_d;
   logic                                    busy_q, busy_d;
   logic                                    done_q, done_d;
   logic                                    in_ready_q, in_ready_d;
   logic                                    accept;

   // Handshake: a word transfers on a rising clk edge where in_valid_i and in_ready_o
   // are both high; in_data_i must be held stable while in_valid_i waits for ready.
   always_comb begin
      state_d         = state_q;
      word_cnt_d      = word_cnt_q;
      staging_d       = staging_q;
      drain_pending_d = drain_pending_q;
      drain_cnt_d     = drain_cnt_q;
      accept          = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (drain_pending_q) begin
               // Partial rows go out zero-padded; staging was cleared after the last step.
               if (word_cnt_q != '0) begin
                  state_d = ST_STEP;
               end else begin
                  state_d     = ST_DRAIN;
                  drain_cnt_d = DRAIN_INIT;
               end
            end else begin
               accept = in_valid_i & in_ready_q;
               if (accept) begin
                  staging_d[word_cnt_q] = in_data_i;
                  if (word_cnt_q == LAST_WORD) begin
                     word_cnt_d = '0;
                     state_d    = ST_STEP;
                  end else begin
                     word_cnt_d = word_cnt_q + CW'(1);
                  end
               end
               if (drain_i) begin
                  drain_pending_d = 1'b1;
               end
            end
         end
         ST_STEP: begin
            staging_d  = '0;
            word_cnt_d = '0;
            if (drain_pending_q) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = DRAIN_INIT;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == DCW'(1)) begin
               state_d         = ST_FILL;
               drain_pending_d = 1'b0;
               drain_cnt_d     = '0;
            end else begin
               drain_cnt_d = drain_cnt_q - DCW'(1);
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase

      stream_d   = (state_d != ST_FILL);
      busy_d     = (state_d != ST_FILL);
      done_d     = (state_d == ST_DRAIN) && (drain_cnt_d == DCW'(1));
      in_ready_d = (state_d == ST_FILL) && !drain_pending_d;
   end

   // Lane r owns r packed entries starting at r*(r-1)/2; the highest one is the oldest.
   always_comb begin
      dly_d = dly_q;
      if (stream_q) begin
         for (int r = 1; r < SA_SIZE; r++) begin
            dly_d[r*(r-1)/2] = staging_q[r];
            for (int i = 1; i < r; i++) begin
               dly_d[r*(r-1)/2 + i] = dly_q[r*(r-1)/2 + i - 1];
            end
         end
      end
   end

   always_comb begin
      sa_inputs_o    = '0;
      sa_inputs_o[0] = staging_q[0];
      for (int r = 1; r < SA_SIZE; r++) begin
         sa_inputs_o[r] = dly_q[r*(r-1)/2 + r - 1];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q         <= ST_FILL;
         word_cnt_q      <= '0;
         staging_q       <= '0;
         dly_q           <= '0;
         drain_pending_q <= 1'b0;
         drain_cnt_q     <= '0;
         stream_q        <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         in_ready_q      <= 1'b1;
      end else begin
         state_q         <= state_d;
         word_cnt_q      <= word_cnt_d;
         staging_q       <= staging_d;
         dly_q           <= dly_d;
         drain_pending_q <= drain_pending_d;
         drain_cnt_q     <= drain_cnt_d;
         stream_q        <= stream_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         in_ready_q      <= in_ready_d;
      end
   end

   assign stream_o   = stream_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign in_ready_o = in_ready_q;

`ifdef SA_SKEW_ROWCNT_EN
   logic [15:0] rows_q, rows_d;

   // Only data rows count; the drain tail is excluded and its final pulse clears the count.
   always_comb begin
      rows_d = rows_q;
      if (done_q) begin
         rows_d = '0;
      end else if (state_q == ST_STEP) begin
         rows_d = rows_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rows_q <= '0;
      end else begin
         rows_q <= rows_d;
      end
   end

   assign rows_streamed_o = rows_q;
`endif

endmodule

// File: tb/tb_sa_input_skewer.sv
// Directed bench for sa_input_skewer (SA_SIZE=4, DRAIN_STEPS=6): expected strobe
// contents are queued as stimulus is issued and a negedge monitor compares them.
module tb_sa_input_skewer;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int EW = 2 + N*W;

   logic                clk = 1'b0;
   logic                resetn = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [W-1:0]        in_data = '0;
   logic                drain = 1'b0;
   logic                stream;
   logic [N-1:0][W-1:0] lanes;
   logic                busy;
   logic                done;
`ifdef SA_SKEW_ROWCNT_EN
   logic [15:0]         rows_streamed;
`endif

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   sa_input_skewer #(
      .SA_SIZE(N),
      .ACTIVATION_SIZE(W),
      .DRAIN_STEPS(6)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .in_valid_i(in_valid),
      .in_ready_o(in_ready),
      .in_data_i(in_data),
      .drain_i(drain),
      .stream_o(stream),
      .sa_inputs_o(lanes),
      .busy_o(busy),
      .done_o(done)
`ifdef SA_SKEW_ROWCNT_EN
      ,
      .rows_streamed_o(rows_streamed)
`endif
   );

   task automatic chk(input string name, input logic [135:0] got, input logic [135:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] l0, l1, l2, l3, input logic d);
      exp_q.push_back({d, 1'b1, l3, l2, l1, l0});
   endtask

   // Monitor: every strobe must match the next queued row image; idle cycles must not pulse done.
   always @(negedge clk) begin
      if (resetn) begin
         if (stream) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe got=%h exp=none t=%0t", {done, busy, lanes}, $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("strobe", {done, busy, lanes}, mon_e);
            end
         end else begin
            chk("idle_done", done, 1'b0);
         end
      end
   end

   task automatic send_word(input logic [W-1:0] d);
      int tries = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && tries < 50) begin
         @(negedge clk);
         tries++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got_ready=0 exp_ready=1 t=%0t", $time);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_row(input logic [W-1:0] w0, w1, w2, w3);
      send_word(w0);
      send_word(w1);
      send_word(w2);
      send_word(w3);
   endtask

   task automatic request_drain();
      int t = 0;
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      drain = 1'b1;
      @(negedge clk);
      drain = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || busy) && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk(name, exp_q.size(), 0);
   endtask

   task automatic fill_row_stalled(input logic [W-1:0] w0, w1, w2, w3, input logic [W-1:0] prev1);
      logic [W-1:0] w [4];
      w = '{w0, w1, w2, w3};
      for (int k = 0; k < 4; k++) begin
         int n = $urandom_range(1, 3);
         repeat (n) begin
            @(negedge clk);
            chk("stall_hold", {stream, in_ready, busy, lanes},
                {1'b0, 1'b1, 1'b0, 32'h0, 32'h0, prev1, (k > 0) ? w0 : 32'h0});
         end
         send_word(w[k]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int run;

      // Reset and idle
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("in_reset", {stream, busy, done, in_ready, lanes}, {4'b0001, 128'h0});
      resetn = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {stream, busy, done, in_ready, lanes}, {4'b0001, 128'h0});

      // Three back-to-back rows then drain
      push_exp(32'h3F800000, 32'h0,        32'h0,        32'h0,        1'b0);
      push_exp(32'h40A00000, 32'h40000000, 32'h0,        32'h0,        1'b0);
      push_exp(32'h41100000, 32'h40C00000, 32'h40400000, 32'h0,        1'b0);
      push_exp(32'h0,        32'h41200000, 32'h40E00000, 32'h40800000, 1'b0);
      push_exp(32'h0,        32'h0,        32'h41300000, 32'h41000000, 1'b0);
      push_exp(32'h0,        32'h0,        32'h0,        32'h41400000, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      send_word(32'h3F800000);
      send_word(32'h40000000);
      send_word(32'h40400000);
      chk("no_early_strobe", stream, 1'b0);
      send_word(32'h40800000);
      chk("first_strobe_latency", stream, 1'b1);
      send_row(32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000);
      send_row(32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000);
      request_drain();
      wait_idle("three_rows_drained");

      // Two rows then drain: exactly six consecutive drain strobes
      push_exp(32'h11110000, 32'h0,        32'h0,        32'h0,        1'b0);
      push_exp(32'h22220000, 32'h11110001, 32'h0,        32'h0,        1'b0);
      push_exp(32'h0,        32'h22220001, 32'h11110002, 32'h0,        1'b0);
      push_exp(32'h0,        32'h0,        32'h22220002, 32'h11110003, 1'b0);
      push_exp(32'h0,        32'h0,        32'h0,        32'h22220003, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      send_row(32'h11110000, 32'h11110001, 32'h11110002, 32'h11110003);
      send_row(32'h22220000, 32'h22220001, 32'h22220002, 32'h22220003);
      request_drain();
      t = 0;
      while (!stream && t < 20) begin
         @(negedge clk);
         t++;
      end
      run = 0;
      while (stream && run < 20) begin
         run++;
         @(negedge clk);
      end
      chk("drain_run_len", run, 6);
      wait_idle("two_rows_drained");

      // Partial row of two words then drain
      push_exp(32'hAAAA0001, 32'h0,        32'h0, 32'h0, 1'b0);
      push_exp(32'h0,        32'hAAAA0002, 32'h0, 32'h0, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      send_word(32'hAAAA0001);
      send_word(32'hAAAA0002);
      request_drain();
      wait_idle("partial_row_drained");

      // Stalled rows: outputs must hold between accepts
      push_exp(32'h0F000000, 32'h0,        32'h0,        32'h0,        1'b0);
      push_exp(32'h06000000, 32'h0F000001, 32'h0,        32'h0,        1'b0);
      push_exp(32'h0,        32'h06000001, 32'h0F000002, 32'h0,        1'b0);
      push_exp(32'h0,        32'h0,        32'h06000002, 32'h0F000003, 1'b0);
      push_exp(32'h0,        32'h0,        32'h0,        32'h06000003, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      fill_row_stalled(32'h0F000000, 32'h0F000001, 32'h0F000002, 32'h0F000003, 32'h0);
      chk("stalled_row_strobe", stream, 1'b1);
      fill_row_stalled(32'h06000000, 32'h06000001, 32'h06000002, 32'h06000003, 32'h0F000001);
      request_drain();
      wait_idle("stalled_rows_drained");

      // Reset asserted in the middle of a drain
      push_exp(32'h3F800000, 32'h0,        32'h0,        32'h0, 1'b0);
      push_exp(32'h0,        32'h40000000, 32'h0,        32'h0, 1'b0);
      push_exp(32'h0,        32'h0,        32'h40400000, 32'h0, 1'b0);
      send_row(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
      request_drain();
      run = 0;
      t = 0;
      while (run < 2 && t < 20) begin
         @(negedge clk);
         t++;
         if (stream) run++;
      end
      chk("reached_mid_drain", run, 2);
      #1 resetn = 1'b0;
      @(negedge clk);
      chk("reset_mid_drain", {stream, busy, done, in_ready, lanes}, {4'b0001, 128'h0});
      resetn = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("post_reset_quiet", {stream, done, busy}, 3'b000);
      end
      chk("post_reset_queue", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
